gate_exhaustive_checker: RTL and testbench



---
 rtl/gate_exhaustive_checker.sv | 130 +++++++++++++
 tb/tb_gate_exhaustive_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gate_exhaustive_checker.sv
// Exhaustive self-test for the AND/OR/XOR/NOT gate block: sweeps all eight A/B/C vectors and scores the responses.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN ends the run at the first failing vector.
module gate_exhaustive_checker #(
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       outAND,
    input  logic       outOR,
    input  logic       outXOR,
    input  logic       notC,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       fail_valid
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_DIV - 2);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    vec_q, vec_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    errCount_q, errCount_d;
    logic [2:0]    firstFail_q, firstFail_d;
    logic          failValid_q, failValid_d;
    logic          vecMismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= 3'd0;
            dwell_q     <= '0;
            errCount_q  <= 4'd0;
            firstFail_q <= 3'd0;
            failValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            errCount_q  <= errCount_d;
            firstFail_q <= firstFail_d;
            failValid_q <= failValid_d;
        end
    end

    // Expected responses come from the vector index itself, not from the driven pins.
    assign vecMismatch = (outAND != (vec_q[2] & vec_q[1]))
                       | (outOR  != (vec_q[2] | vec_q[1]))
                       | (outXOR != (vec_q[2] ^ vec_q[1]))
                       | (notC   != ~vec_q[0]);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        errCount_d  = errCount_q;
        firstFail_d = firstFail_q;
        failValid_d = failValid_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_d       = 3'd0;
                    dwell_d     = '0;
                    errCount_d  = 4'd0;
                    firstFail_d = 3'd0;
                    failValid_d = 1'b0;
                end
            end
            DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (vecMismatch) begin
                    errCount_d = errCount_q + 4'd1;
                    if (!failValid_q) begin
                        firstFail_d = vec_q;
                        failValid_d = 1'b1;
                    end
                end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                if (vecMismatch || vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    dwell_d = '0;
                    state_d = DRIVE;
                end
`else
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    dwell_d = '0;
                    state_d = DRIVE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign {A, B, C}      = (state_q == IDLE) ? 3'b000 : vec_q;
    assign busy           = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done           = (state_q == DONE);
    assign pass           = done && (errCount_q == 4'd0);
    assign err_count      = errCount_q;
    assign first_fail_vec = firstFail_q;
    assign fail_valid     = failValid_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Directed bench for gate_exhaustive_checker: a behavioural gate block with injectable faults feeds the checker.
// Expectations track GATE_CHECK_STOP_ON_FAIL_EN when the bench is built with it.
module tb_gate_exhaustive_checker;

   logic       clk;
   logic       reset;
   logic       start;
   logic       A, B, C;
   logic       outAND, outOR, outXOR, notC;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_fail_vec;
   logic       fail_valid;

   int faultMode;
   int assertCount;
   int failCount;

   gate_exhaustive_checker #(.STEP_DIV(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .A             (A),
      .B             (B),
      .C             (C),
      .outAND        (outAND),
      .outOR         (outOR),
      .outXOR        (outXOR),
      .notC          (notC),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_fail_vec(first_fail_vec),
      .fail_valid    (fail_valid)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate block model: mode 1 sticks XOR at 0, mode 2 wires notC straight to C.
   always_comb begin
      outAND = A & B;
      outOR  = A | B;
      outXOR = (faultMode == 1) ? 1'b0 : (A ^ B);
      notC   = (faultMode == 2) ? C : ~C;
   end

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs and samples happen 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".abc"},   {29'd0, A, B, C}, 32'd0);
      checkOutput({tag, ".busy"},  {31'd0, busy}, 32'd0);
      checkOutput({tag, ".done"},  {31'd0, done}, 32'd0);
      checkOutput({tag, ".pass"},  {31'd0, pass}, 32'd0);
      checkOutput({tag, ".err"},   {28'd0, err_count}, 32'd0);
      checkOutput({tag, ".first"}, {29'd0, first_fail_vec}, 32'd0);
      checkOutput({tag, ".fv"},    {31'd0, fail_valid}, 32'd0);
   endtask

   // Starts a run, optionally pulses start again at cycle pulseAt, then checks timing and final verdict.
   task automatic applyStimulus(input string tag, input int fault, input int pulseAt,
                                input int expDoneCycle, input int expErr, input int expFirst,
                                input int expFv, input int expPass, input int expAbc);
      int  n;
      bit  allBusy;
      faultMode = fault;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      checkOutput({tag, ".busyAtStart"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, ".abcAtStart"},  {29'd0, A, B, C}, 32'd0);
      allBusy = busy;
      while (!done && n < 400) begin
         if (n == pulseAt) start = 1'b1;
         tick();
         start = 1'b0;
         n++;
         if (!done && !busy) allBusy = 1'b0;
      end
      checkOutput({tag, ".doneCycle"}, n, expDoneCycle);
      checkOutput({tag, ".busyRun"},   {31'd0, allBusy}, 32'd1);
      checkOutput({tag, ".busyDone"},  {31'd0, busy}, 32'd0);
      checkOutput({tag, ".pass"},      {31'd0, pass}, expPass);
      checkOutput({tag, ".err"},       {28'd0, err_count}, expErr);
      checkOutput({tag, ".first"},     {29'd0, first_fail_vec}, expFirst);
      checkOutput({tag, ".fv"},        {31'd0, fail_valid}, expFv);
      checkOutput({tag, ".abcDone"},   {29'd0, A, B, C}, expAbc);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      faultMode   = 0;
      reset       = 1'b1;
      start       = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      checkResetState("reset");

      // Clean sweep, with a start pulse at cycle 5 that must be ignored.
      applyStimulus("clean", 0, 5, 33, 0, 0, 0, 1, 7);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
      applyStimulus("xorStuck", 1, -1, 13, 1, 2, 1, 0, 2);
`else
      applyStimulus("xorStuck", 1, -1, 33, 4, 2, 1, 0, 7);
`endif

      // Restart from DONE clears results on the next cycle and begins at vector 000.
      faultMode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("restart.done", {31'd0, done}, 32'd0);
      checkOutput("restart.busy", {31'd0, busy}, 32'd1);
      checkOutput("restart.err",  {28'd0, err_count}, 32'd0);
      checkOutput("restart.fv",   {31'd0, fail_valid}, 32'd0);
      checkOutput("restart.first",{29'd0, first_fail_vec}, 32'd0);
      checkOutput("restart.abc",  {29'd0, A, B, C}, 32'd0);

      // Let the run reach cycle 10, then reset in that cycle.
      for (int i = 0; i < 9; i++) tick();
      checkOutput("midRun.busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkResetState("midReset");

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
      applyStimulus("notCtied", 2, -1, 5, 1, 0, 1, 0, 0);
`else
      applyStimulus("notCtied", 2, -1, 33, 8, 0, 1, 0, 7);
`endif

      applyStimulus("cleanAgain", 0, -1, 33, 0, 0, 0, 1, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
